// File: rtl/ibex_ex_issue_ctrl.sv
// Issue/writeback control for one in-flight EX instruction:
// accept -> EXEC (multi-cycle, timeout-guarded) -> WB handshake.
module ibex_ex_issue_ctrl #(
    parameter int unsigned MaxCycles = 40
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic             op_mult_i,
    input  logic             op_div_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             flush_i,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             alu_instr_first_cycle_o,
    output logic             multdiv_ready_id_o,
    input  logic             ex_valid_i,
    input  logic [31:0]      result_ex_i,
    input  logic [1:0]       imd_val_we_i,
    input  logic [1:0][33:0] imd_val_d_i,
    output logic [1:0][33:0] imd_val_q_o,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [4:0]       wb_rd_addr_o,
    output logic [31:0]      wb_data_o,
    output logic             busy_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    localparam logic [5:0] CntLimit = 6'(MaxCycles - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_mult;
    logic             r_div;
    logic [4:0]       r_rd_addr;
    logic [5:0]       r_cycle_cnt;
    logic [31:0]      r_wb_data;
    logic [1:0][33:0] r_imd_val;

    logic w_in_exec;
    logic w_instr_ready;
    logic w_accept;
    logic w_complete;
    logic w_timeout;

    assign w_in_exec     = (r_state == EXEC);
    assign w_instr_ready = !flush_i && ((r_state == IDLE) || ((r_state == WB) && wb_ready_i));
    assign w_accept      = instr_valid_i && w_instr_ready;
    // ex_valid_i beats the timeout in the same cycle; flush_i overrides both.
    assign w_complete    = w_in_exec && ex_valid_i && !flush_i;
    assign w_timeout     = w_in_exec && !ex_valid_i && !flush_i && (r_cycle_cnt >= CntLimit);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_next            = r_state;
        instr_ready_o           = w_instr_ready;
        mult_en_o               = 1'b0;
        div_en_o                = 1'b0;
        alu_instr_first_cycle_o = 1'b0;
        multdiv_ready_id_o      = 1'b0;
        wb_valid_o              = 1'b0;
        busy_o                  = 1'b1;
        timeout_o               = w_timeout;

        unique case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (w_accept) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                mult_en_o               = r_mult;
                div_en_o                = r_div;
                alu_instr_first_cycle_o = (r_cycle_cnt == 6'd0);
                multdiv_ready_id_o      = 1'b1;
                if (w_complete) begin
                    w_state_next = WB;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            WB: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    w_state_next = w_accept ? EXEC : IDLE;
                end
            end
            default: begin
                busy_o       = 1'b0;
                w_state_next = IDLE;
            end
        endcase

        if (flush_i) begin
            w_state_next = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_mult      <= 1'b0;
            r_div       <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_cycle_cnt <= 6'd0;
            r_wb_data   <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mult      <= op_mult_i;
                r_div       <= op_div_i;
                r_rd_addr   <= rd_addr_i;
                r_cycle_cnt <= 6'd0;
            end else if (w_in_exec && !ex_valid_i && (r_cycle_cnt != 6'h3F)) begin
                r_cycle_cnt <= r_cycle_cnt + 6'd1;
            end
            if (w_complete) begin
                r_wb_data <= result_ex_i;
            end
        end
    end

    // NOTE: the intermediate-value registers are reset, yet deliberately survive completion and flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_imd_val <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_in_exec && imd_val_we_i[i]) begin
                    r_imd_val[i] <= imd_val_d_i[i];
                end
            end
        end
    end

    assign imd_val_q_o  = r_imd_val;
    assign wb_rd_addr_o = r_rd_addr;
    assign wb_data_o    = r_wb_data;

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// Self-checking bench for ibex_ex_issue_ctrl: directed phases plus a writeback
// scoreboard popped on every wb_valid_o & wb_ready_i handshake.
module tb_ibex_ex_issue_ctrl;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    logic             clk;
    logic             rst;
    logic             instr_valid;
    logic             instr_ready;
    logic             op_mult;
    logic             op_div;
    logic [4:0]       rd_addr;
    logic             flush;
    logic             mult_en;
    logic             div_en;
    logic             first_cycle;
    logic             md_ready;
    logic             ex_valid;
    logic [31:0]      result_ex;
    logic [1:0]       imd_we;
    logic [1:0][33:0] imd_d;
    logic [1:0][33:0] imd_q;
    logic             wb_valid;
    logic             wb_ready;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             busy;
    logic             timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int first_cnt = 0;
    int div_cnt   = 0;
    int to_cnt    = 0;
    int wb_seen   = 0;
    wb_exp_t sb_q[$];

    ibex_ex_issue_ctrl #(.MaxCycles(40)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .instr_valid_i           (instr_valid),
        .instr_ready_o           (instr_ready),
        .op_mult_i               (op_mult),
        .op_div_i                (op_div),
        .rd_addr_i               (rd_addr),
        .flush_i                 (flush),
        .mult_en_o               (mult_en),
        .div_en_o                (div_en),
        .alu_instr_first_cycle_o (first_cycle),
        .multdiv_ready_id_o      (md_ready),
        .ex_valid_i              (ex_valid),
        .result_ex_i             (result_ex),
        .imd_val_we_i            (imd_we),
        .imd_val_d_i             (imd_d),
        .imd_val_q_o             (imd_q),
        .wb_valid_o              (wb_valid),
        .wb_ready_i              (wb_ready),
        .wb_rd_addr_o            (wb_rd),
        .wb_data_o               (wb_data),
        .busy_o                  (busy),
        .timeout_o               (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: event counters and the writeback scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (first_cycle === 1'b1) first_cnt++;
            if (div_en === 1'b1)      div_cnt++;
            if (timeout === 1'b1)     to_cnt++;
            if (wb_valid === 1'b1)    wb_seen++;
            if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    wb_exp_t e;
                    e = sb_q.pop_front();
                    check("sb_wb_data", 64'(wb_data), 64'(e.data));
                    check("sb_wb_rd", 64'(wb_rd), 64'(e.rd));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic mult, input logic div, input logic [4:0] rd, input string tag);
        instr_valid = 1'b1;
        op_mult     = mult;
        op_div      = div;
        rd_addr     = rd;
        settle();
        check({tag, "_instr_ready"}, 64'(instr_ready), 64'd1);
        tick();
        instr_valid = 1'b0;
        op_mult     = 1'b0;
        op_div      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
        check({tag, "_mult_en"}, 64'(mult_en), 64'd0);
        check({tag, "_div_en"}, 64'(div_en), 64'd0);
        check({tag, "_first"}, 64'(first_cycle), 64'd0);
        check({tag, "_md_ready"}, 64'(md_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_instr_ready"}, 64'(instr_ready), 64'd1);
        check({tag, "_wb_data"}, 64'(wb_data), 64'd0);
        check({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
        check({tag, "_imd1"}, 64'(imd_q[1]), 64'd0);
        check({tag, "_imd0"}, 64'(imd_q[0]), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0, d0, t0, w0;
        wb_exp_t e;

        rst = 1'b1; instr_valid = 1'b0; op_mult = 1'b0; op_div = 1'b0; rd_addr = 5'd0;
        flush = 1'b0; ex_valid = 1'b0; result_ex = 32'd0; imd_we = 2'b00; imd_d = '0;
        wb_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check_reset_outputs("reset");

        // ALU op, result in EXEC cycle 1.
        f0 = first_cnt;
        issue(1'b0, 1'b0, 5'd5, "alu");
        ex_valid = 1'b1; result_ex = 32'h0000_00AA;
        settle();
        check("alu_first_c1", 64'(first_cycle), 64'd1);
        check("alu_md_ready", 64'(md_ready), 64'd1);
        check("alu_mult_en", 64'(mult_en), 64'd0);
        e.rd = 5'd5; e.data = 32'h0000_00AA; sb_q.push_back(e);
        tick();
        ex_valid = 1'b0;
        settle();
        check("alu_wb_valid", 64'(wb_valid), 64'd1);
        check("alu_wb_data", 64'(wb_data), 64'h0000_00AA);
        check("alu_wb_rd", 64'(wb_rd), 64'd5);
        tick();
        check("alu_idle", 64'(busy), 64'd0);
        check("alu_first_count", 64'(first_cnt - f0), 64'd1);

        // DIV over 34 EXEC cycles with intermediate writes in cycle 2.
        d0 = div_cnt; t0 = to_cnt;
        issue(1'b0, 1'b1, 5'd7, "div");
        for (int c = 1; c <= 34; c++) begin
            imd_we   = (c == 2) ? 2'b11 : 2'b00;
            imd_d[1] = 34'h3_0000_0001;
            imd_d[0] = 34'h0_DEAD_BEEF;
            ex_valid = (c == 34);
            result_ex = 32'h0000_0D1D;
            if (c == 34) begin
                e.rd = 5'd7; e.data = 32'h0000_0D1D; sb_q.push_back(e);
            end
            tick();
        end
        ex_valid = 1'b0; imd_we = 2'b00;
        settle();
        check("div_wb_valid", 64'(wb_valid), 64'd1);
        tick();
        check("div_en_cycles", 64'(div_cnt - d0), 64'd34);
        check("div_no_timeout", 64'(to_cnt - t0), 64'd0);
        check("div_imd1", 64'(imd_q[1]), 64'h3_0000_0001);
        check("div_imd0", 64'(imd_q[0]), 64'h0_DEAD_BEEF);
        imd_we = 2'b11; imd_d = '0;
        tick();
        imd_we = 2'b00;
        check("imd_idle_write_ignored", 64'(imd_q[0]), 64'h0_DEAD_BEEF);

        // Backpressure for 3 cycles, then back-to-back accept.
        issue(1'b1, 1'b0, 5'd9, "mul");
        ex_valid = 1'b1; result_ex = 32'h1234_5678;
        settle();
        check("mul_mult_en", 64'(mult_en), 64'd1);
        e.rd = 5'd9; e.data = 32'h1234_5678; sb_q.push_back(e);
        tick();
        ex_valid = 1'b0; result_ex = 32'hFFFF_FFFF; wb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("bp_wb_valid", 64'(wb_valid), 64'd1);
            check("bp_wb_data", 64'(wb_data), 64'h1234_5678);
            check("bp_instr_ready", 64'(instr_ready), 64'd0);
            tick();
        end
        wb_ready = 1'b1;
        issue(1'b0, 1'b0, 5'd10, "b2b");
        check("b2b_exec", 64'(md_ready), 64'd1);
        check("b2b_first", 64'(first_cycle), 64'd1);
        check("b2b_mult_off", 64'(mult_en), 64'd0);
        check("b2b_new_rd", 64'(wb_rd), 64'd10);
        ex_valid = 1'b1; result_ex = 32'h0000_0055;
        e.rd = 5'd10; e.data = 32'h0000_0055; sb_q.push_back(e);
        tick();
        ex_valid = 1'b0;
        tick();

        // Timeout with no ex_valid: pulse in EXEC cycle 40.
        t0 = to_cnt; w0 = wb_seen;
        issue(1'b0, 1'b1, 5'd3, "to");
        for (int c = 1; c <= 40; c++) begin
            settle();
            if (c == 39) check("to_c39", 64'(timeout), 64'd0);
            if (c == 40) check("to_c40", 64'(timeout), 64'd1);
            tick();
        end
        check("to_idle", 64'(busy), 64'd0);
        check("to_pulse_count", 64'(to_cnt - t0), 64'd1);
        check("to_no_wb", 64'(wb_seen - w0), 64'd0);

        // ex_valid on EXEC cycle 40 beats the timeout.
        t0 = to_cnt;
        issue(1'b0, 1'b1, 5'd4, "to2");
        for (int c = 1; c <= 40; c++) begin
            ex_valid = (c == 40);
            result_ex = 32'h0000_CAFE;
            if (c == 40) begin
                settle();
                check("to2_c40_timeout", 64'(timeout), 64'd0);
                e.rd = 5'd4; e.data = 32'h0000_CAFE; sb_q.push_back(e);
            end
            tick();
        end
        ex_valid = 1'b0;
        settle();
        check("to2_wb_valid", 64'(wb_valid), 64'd1);
        tick();
        check("to2_no_pulse", 64'(to_cnt - t0), 64'd0);

        // Flush in EXEC cycle 3 of a MUL, with ex_valid in the same cycle.
        w0 = wb_seen;
        issue(1'b1, 1'b0, 5'd12, "fl");
        tick();
        tick();
        flush = 1'b1; ex_valid = 1'b1; result_ex = 32'hBAD0_BAD0;
        settle();
        check("fl_instr_ready", 64'(instr_ready), 64'd0);
        tick();
        flush = 1'b0; ex_valid = 1'b0;
        settle();
        check("fl_idle", 64'(busy), 64'd0);
        check("fl_mult_off", 64'(mult_en), 64'd0);
        check("fl_wb_valid", 64'(wb_valid), 64'd0);
        tick();
        tick();
        check("fl_no_wb", 64'(wb_seen - w0), 64'd0);
        flush = 1'b1; instr_valid = 1'b1;
        settle();
        check("fl_idle_ready", 64'(instr_ready), 64'd0);
        tick();
        flush = 1'b0; instr_valid = 1'b0;
        settle();
        check("fl_not_accepted", 64'(busy), 64'd0);

        // Reset while holding a result in WB.
        wb_ready = 1'b0;
        issue(1'b0, 1'b0, 5'd20, "rwb");
        ex_valid = 1'b1; result_ex = 32'h0000_0077;
        tick();
        ex_valid = 1'b0;
        settle();
        check("rwb_in_wb", 64'(wb_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check_reset_outputs("rwb");
        wb_ready = 1'b1;
        tick();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_ex_issue_ctrl.md
IBEX_EX_ISSUE_CTRL -- requirements
Module: ibex_ex_issue_ctrl

Interface
REQ-001 The block SHALL have parameter MaxCycles, default 40: EXEC cycles allowed before timeout abort (range 2..63).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk_i input 1 is the clock; rst_i input 1 is the reset.
REQ-003 The block SHALL have instr_valid_i input 1: decoder offers an instruction.
REQ-004 The block SHALL have instr_ready_o output 1: instruction accepted this cycle when high with instr_valid_i.
REQ-005 The block SHALL have op_mult_i input 1 and op_div_i input 1: instruction class, sampled at accept; both low means ALU.
REQ-006 The block SHALL have rd_addr_i input 5: destination register, sampled at accept.
REQ-007 The block SHALL have flush_i input 1: kill in-flight instruction.
REQ-008 The block SHALL have mult_en_o output 1, div_en_o output 1 and alu_instr_first_cycle_o output 1: EX block controls.
REQ-009 The block SHALL have multdiv_ready_id_o output 1: ID ready to take the EX result.
REQ-010 The block SHALL have ex_valid_i input 1 and result_ex_i input 32: EX result handshake.
REQ-011 The block SHALL have imd_val_we_i input 2, imd_val_d_i input 2x34 and imd_val_q_o output 2x34: intermediate value register port.
REQ-012 The block SHALL have wb_valid_o output 1, wb_ready_i input 1, wb_rd_addr_o output 5 and wb_data_o output 32: writeback handshake.
REQ-013 The block SHALL have busy_o output 1 (state != IDLE) and timeout_o output 1 (one-cycle abort pulse).

Function
REQ-014 The FSM SHALL have the states IDLE, EXEC and WB.
REQ-015 instr_ready_o SHALL equal !flush_i & (IDLE | (WB & wb_ready_i)).
REQ-016 On accept, the block SHALL latch class and rd_addr_i, clear cycle_cnt to 0, and go to EXEC next cycle.
REQ-017 alu_instr_first_cycle_o SHALL be high only in the first EXEC cycle of each instruction.
REQ-018 In EXEC, mult_en_o SHALL equal the latched mult bit and div_en_o SHALL equal the latched div bit; outside EXEC both SHALL be 0.
REQ-019 multdiv_ready_id_o SHALL be high in every EXEC cycle and low otherwise.
REQ-020 In EXEC, ex_valid_i=1 SHALL capture result_ex_i into wb_data_o and move to WB next cycle; latency from accept to wb_valid_o is N+1 cycles, where N is the EXEC cycle in which ex_valid_i is seen (N>=1).
REQ-021 In WB, wb_valid_o SHALL be 1, and wb_data_o and wb_rd_addr_o SHALL be stable until wb_ready_i=1.
REQ-022 On wb_ready_i=1 in WB: with a new accept the block SHALL go to EXEC (back-to-back), otherwise to IDLE.
REQ-023 imd_val register i SHALL load imd_val_d_i[i] when imd_val_we_i[i]=1 in EXEC; writes in other states SHALL be ignored.
REQ-024 imd_val registers SHALL NOT be cleared at completion or flush.
REQ-025 cycle_cnt (6 bit) SHALL increment in each EXEC cycle without ex_valid_i and SHALL saturate, never wrap.
REQ-026 If cycle_cnt reaches MaxCycles-1 in EXEC without ex_valid_i, the block SHALL pulse timeout_o for one cycle and go to IDLE, writing nothing back.
REQ-027 ex_valid_i in the same cycle as the timeout condition SHALL win: the result completes normally and timeout_o stays 0.
REQ-028 flush_i SHALL take priority over ex_valid_i, timeout and accept.
REQ-029 On flush_i, the next state SHALL be IDLE, and wb_valid_o, mult_en_o and div_en_o SHALL be 0 from the next cycle.
REQ-030 A WB entry that is flushed SHALL be discarded.
REQ-031 ex_valid_i outside EXEC SHALL be ignored.

Reset
REQ-032 While rst_i is high at a clk_i edge, the state SHALL go to IDLE and cycle_cnt, wb_data_o, wb_rd_addr_o and both imd_val registers SHALL be cleared to 0.
REQ-033 From reset, wb_valid_o, mult_en_o, div_en_o, alu_instr_first_cycle_o, multdiv_ready_id_o, busy_o and timeout_o SHALL be 0, and instr_ready_o SHALL be 1 (given flush_i=0).
REQ-034 Reset mid-EXEC or mid-WB SHALL drop the instruction with no wb_valid_o pulse.

Verification
REQ-035 The bench SHALL cover an ALU op: accept rd=5, ex_valid_i in EXEC cycle 1 with result 0x0000_00AA -> wb_valid_o 2 cycles after accept, wb_data_o=0x0000_00AA, wb_rd_addr_o=5, first_cycle high exactly 1 cycle.
REQ-036 The bench SHALL cover a DIV: ex_valid_i on EXEC cycle 34, imd_val_we_i=2'b11 with d={0x3_0000_0001, 0x0_DEAD_BEEF} in cycle 2 -> div_en_o high 34 cycles, imd_val_q_o holds those values afterwards, timeout_o stays 0.
REQ-037 The bench SHALL cover backpressure and back-to-back: wb_ready_i held 0 for 3 cycles -> wb_data_o stable; then wb_ready_i=1 with instr_valid_i=1 -> accept in the same cycle, EXEC next cycle.
REQ-038 The bench SHALL cover timeout: MaxCycles=40, ex_valid_i never asserted -> timeout_o pulses in EXEC cycle 40, then IDLE, no wb_valid_o; repeat with ex_valid_i in cycle 40 -> normal writeback.
REQ-039 The bench SHALL cover flush: flush_i in EXEC cycle 3 of a MUL with simultaneous ex_valid_i -> IDLE next cycle, no writeback; flush_i with instr_valid_i in IDLE -> instr_ready_o=0.
REQ-040 The bench SHALL cover reset during WB: rst_i for 1 cycle -> all outputs at their reset values on the next cycle, imd_val_q_o=0.
